// File: rtl/intdiv_ctrl.sv
// intdiv_ctrl: iterative radix-2 non-restoring divider with start/busy/done sequencer.
// Latency: done WIDTH+2 cycles after the start edge (1 cycle on divide-by-zero).
// Backpressure: none; start is only accepted in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   start, sgn                 request and signed-mode select, sampled in IDLE/DONE
//   dividend, divisor          WIDTH-bit operands, sampled with start
//   busy, done                 busy in LOAD/ITER/CORR, done is a one-cycle result pulse
//   dz, quotient, remainder    results, held until the next accepted start
//   sd_valid, sd_digit, sd_idx per-step SD2 quotient digit (01=+1, 11=-1), MSB first
//   neg_en                     negation enable for the downstream SD2 stage
module intdiv_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sgn,
  input  logic [WIDTH-1:0]         dividend,
  input  logic [WIDTH-1:0]         divisor,
  output logic                     busy,
  output logic                     done,
  output logic                     dz,
  output logic [WIDTH-1:0]         quotient,
  output logic [WIDTH-1:0]         remainder,
  output logic [1:0]               sd_digit,
  output logic                     sd_valid,
  output logic [$clog2(WIDTH)-1:0] sd_idx,
  output logic                     neg_en
);

  localparam int IW = $clog2(WIDTH);
  localparam int RW = WIDTH + 2;  // partial remainder, two's complement

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_CORR, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  a_op, b_op;    // raw operands captured at start
  logic              sgn_q;
  logic              zdiv;          // accepted request had a zero divisor
  logic [WIDTH-1:0]  n_mag, d_mag;
  logic              qneg, rneg;
  logic [RW-1:0]     r;
  logic [WIDTH-1:0]  p;             // 1 where the digit was +1
  logic [IW-1:0]     cnt;

  // Operand magnitudes, formed in LOAD from the captured operands.
  logic              a_neg, b_neg;
  logic [WIDTH-1:0]  a_mag, b_mag;

  always_comb begin
    a_neg = sgn_q & a_op[WIDTH-1];
    b_neg = sgn_q & b_op[WIDTH-1];
    a_mag = a_neg ? -a_op : a_op;
    b_mag = b_neg ? -b_op : b_op;
  end

  // One non-restoring step: the sign of the current remainder picks the digit.
  logic              r_neg;
  logic [RW-1:0]     d_ext, r_sh, r_step;

  always_comb begin
    r_neg  = r[RW-1];
    d_ext  = {2'b00, d_mag};
    r_sh   = {r[RW-2:0], n_mag[cnt]};
    r_step = r_neg ? r_sh + d_ext : r_sh - d_ext;
  end

  // Final correction. Q = 2P - (2^WIDTH - 1) reduces to 2P + 1 mod 2^WIDTH.
  // Only the low WIDTH bits of the corrected remainder are needed.
  logic [WIDTH-1:0]  q_raw, q_fix, q_fin, r_low, r_fin;

  always_comb begin
    q_raw = (p << 1) | WIDTH'(1);
    q_fix = r_neg ? q_raw - WIDTH'(1) : q_raw;
    q_fin = qneg ? -q_fix : q_fix;
    r_low = r_neg ? r[WIDTH-1:0] + d_mag : r[WIDTH-1:0];
    r_fin = rneg ? -r_low : r_low;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        busy      = 1'b1;
        // A zero divisor skips the iterations and finishes straight from LOAD.
        state_nxt = zdiv ? S_DONE : S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_CORR;
      end
      S_CORR: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = start ? S_LOAD : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_op      <= '0;
      b_op      <= '0;
      sgn_q     <= 1'b0;
      zdiv      <= 1'b0;
      n_mag     <= '0;
      d_mag     <= '0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      r         <= '0;
      p         <= '0;
      cnt       <= '0;
      dz        <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      sd_digit  <= 2'b00;
      sd_valid  <= 1'b0;
      sd_idx    <= '0;
      neg_en    <= 1'b0;
    end else begin
      sd_valid <= 1'b0;
      sd_digit <= 2'b00;
      sd_idx   <= '0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_op  <= dividend;
            b_op  <= divisor;
            sgn_q <= sgn;
            zdiv  <= (divisor == '0);
            dz    <= 1'b0;
          end
        end
        S_LOAD: begin
          if (zdiv) begin
            dz        <= 1'b1;
            quotient  <= '1;
            remainder <= a_op;
            neg_en    <= 1'b0;
          end else begin
            n_mag  <= a_mag;
            d_mag  <= b_mag;
            qneg   <= a_neg ^ b_neg;
            rneg   <= a_neg;
            neg_en <= a_neg ^ b_neg;
            r      <= '0;
            p      <= '0;
            cnt    <= IW'(WIDTH - 1);
          end
        end
        S_ITER: begin
          r        <= r_step;
          p[cnt]   <= ~r_neg;
          sd_valid <= 1'b1;
          sd_digit <= r_neg ? 2'b11 : 2'b01;
          sd_idx   <= cnt;
          if (cnt != '0) cnt <= cnt - IW'(1);
        end
        S_CORR: begin
          quotient  <= q_fin;
          remainder <= r_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_ctrl.sv
// tb_intdiv_ctrl: scoreboard bench for intdiv_ctrl (WIDTH=8 main instance, WIDTH=3 digit-stream instance).
// Expected results come from plain integer division on operand magnitudes.
// A negedge monitor pops the scoreboard on every done pulse.
module tb_intdiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, sgn;
  logic [7:0] dividend, divisor;
  logic       busy, done, dz, sd_valid, neg_en;
  logic [7:0] quotient, remainder;
  logic [1:0] sd_digit;
  logic [2:0] sd_idx;

  intdiv_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .dz(dz),
    .quotient(quotient), .remainder(remainder),
    .sd_digit(sd_digit), .sd_valid(sd_valid), .sd_idx(sd_idx), .neg_en(neg_en)
  );

  logic       x_start, x_sgn;
  logic [2:0] x_dividend, x_divisor;
  logic       x_busy, x_done, x_dz, x_sd_valid, x_neg_en;
  logic [2:0] x_quotient, x_remainder;
  logic [1:0] x_sd_digit;
  logic [1:0] x_sd_idx;

  intdiv_ctrl #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(x_start), .sgn(x_sgn),
    .dividend(x_dividend), .divisor(x_divisor),
    .busy(x_busy), .done(x_done), .dz(x_dz),
    .quotient(x_quotient), .remainder(x_remainder),
    .sd_digit(x_sd_digit), .sd_valid(x_sd_valid), .sd_idx(x_sd_idx), .neg_en(x_neg_en)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ne;
    int         lat;
    int         nd;
    longint     q0;   // magnitude quotient, used to sanity-check the digit stream
    int         e0;   // index of the edge that sampled start
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t   e;
    longint na, nb, q0, r0;
    logic   qn, rn;
    e.e0 = 0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.ne = 1'b0;
      e.lat = 1; e.nd = 0; e.q0 = 0;
    end else begin
      qn = s & (a[7] ^ b[7]);
      rn = s & a[7];
      na = (s && a[7]) ? 256 - longint'(a) : longint'(a);
      nb = (s && b[7]) ? 256 - longint'(b) : longint'(b);
      q0 = na / nb;
      r0 = na % nb;
      e.q  = qn ? 8'(-q0) : 8'(q0);
      e.r  = rn ? 8'(-r0) : 8'(r0);
      e.dz = 1'b0; e.ne = qn;
      e.lat = 10; e.nd = 8; e.q0 = q0;
    end
    return e;
  endfunction

  // Monitor: digit stream bookkeeping, result checks on done, result hold checks otherwise.
  exp_t       me;
  int         ndig = 0;
  int         nidx = 7;
  longint     acc  = 0;
  logic [7:0] hq   = 8'd0;
  logic [7:0] hr   = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ndig = 0; nidx = 7; acc = 0; hq = 8'd0; hr = 8'd0;
    end else begin
      if (sd_valid) begin
        if (sb.size() == 0) chk("sd_unexpected", 1, 0);
        else begin
          chk("sd_idx", sd_idx, nidx);
          chk("sd_digit_legal", (sd_digit == 2'b01 || sd_digit == 2'b11), 1);
          chk("neg_en_run", neg_en, sb[0].ne);
        end
        if (sd_digit == 2'b01) acc = acc + (longint'(1) << sd_idx);
        else                   acc = acc - (longint'(1) << sd_idx);
        ndig++;
        nidx--;
      end
      if (done) begin
        if (sb.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          me = sb.pop_front();
          chk("quotient", quotient, me.q);
          chk("remainder", remainder, me.r);
          chk("dz", dz, me.dz);
          chk("neg_en_done", neg_en, me.ne);
          chk("latency", cyc - me.e0, me.lat);
          chk("digit_count", ndig, me.nd);
          if (!me.dz) chk("digit_sum", (acc == me.q0 || acc == me.q0 + 1), 1);
        end
        hq = quotient; hr = remainder;
        ndig = 0; nidx = 7; acc = 0;
      end else begin
        chk("quotient_hold", quotient, hq);
        chk("remainder_hold", remainder, hr);
      end
    end
  end

  logic [3:0] xd[$];
  always @(negedge clk) if (x_sd_valid) xd.push_back({x_sd_idx, x_sd_digit});

  // Caller sits at a negedge; start is sampled by the next rising edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
    exp_t e;
    dividend = a; divisor = b; sgn = s; start = 1'b1;
    e = model(a, b, s);
    e.e0 = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic s);
    issue(a, b, s);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] xexp [3];
    int         xe0;
    bit         xseen;
    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; dividend = 8'd0; divisor = 8'd0;
    x_start = 1'b0; x_sgn = 1'b0; x_dividend = 3'd0; x_divisor = 3'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dz", dz, 0);
    chk("rst_sd_valid", sd_valid, 0);
    chk("rst_neg_en", neg_en, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=3 digit stream: 7/2.
    x_dividend = 3'd7; x_divisor = 3'd2; x_start = 1'b1; xe0 = cyc + 1;
    @(negedge clk);
    x_start = 1'b0;
    xseen = 1'b0;
    for (int i = 0; i < 20 && !xseen; i++) begin
      if (x_done) xseen = 1'b1;
      else @(negedge clk);
    end
    chk("w3_done_seen", xseen, 1);
    chk("w3_latency", cyc - xe0, 5);
    chk("w3_quotient", x_quotient, 3);
    chk("w3_remainder", x_remainder, 1);
    chk("w3_dz", x_dz, 0);
    xexp[0] = 4'b1001; xexp[1] = 4'b0111; xexp[2] = 4'b0001;
    chk("w3_digit_count", xd.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < xd.size()) chk("w3_digit", xd[i], xexp[i]);
    @(negedge clk);

    run(8'd200, 8'd7, 1'b0);
    run(8'h9C, 8'd7, 1'b1);
    run(8'h80, 8'hFF, 1'b1);
    run(8'd55, 8'd0, 1'b0);

    // start while busy must be ignored.
    issue(8'd200, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 8'd13; divisor = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Back-to-back: each new start lands in the previous DONE cycle.
    issue(8'd100, 8'd3, 1'b0);
    wait_done();
    issue(8'hF9, 8'd2, 1'b1);
    wait_done();
    issue(8'd9, 8'd0, 1'b1);
    wait_done();
    issue(8'd0, 8'd5, 1'b0);
    wait_done();
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      issue(ra, rb, 1'($urandom_range(0, 1)));
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);

    // Reset in the middle of ITER.
    issue(8'h9C, 8'd7, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_dz", dz, 0);
    chk("midrst_sd_valid", sd_valid, 0);
    chk("midrst_sd_digit", sd_digit, 0);
    chk("midrst_sd_idx", sd_idx, 0);
    chk("midrst_neg_en", neg_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(8'd200, 8'd7, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intdiv_ctrl.md
# intdiv_ctrl

Iterative radix-2 non-restoring integer divider with its own sequencer. It takes a WIDTH-bit dividend and divisor under a start/busy/done handshake, and runs one non-restoring step per clock. Each step's quotient digit is emitted in SD2 encoding for the downstream digit-negation stage, together with that stage's negation enable. At the end, the controller delivers the corrected two's-complement quotient and remainder.

## Interface
- WIDTH, 8, operand/quotient/remainder width (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- sgn  in  1  1 = operands are two's-complement signed, 0 = unsigned
- dividend  in  WIDTH  sampled with start
- divisor  in  WIDTH  sampled with start
- busy  out  1  high in LOAD, ITER, CORR
- done  out  1  one-cycle pulse, results valid
- dz  out  1  divide-by-zero flag, valid with done, held until next accepted start
- quotient  out  WIDTH  held from done until next accepted start
- remainder  out  WIDTH  held from done until next accepted start
- sd_digit  out  2  SD2 quotient digit: 01 = +1, 11 = −1 (10 never driven), 00 when not valid
- sd_valid  out  1  sd_digit/sd_idx valid
- sd_idx  out  $clog2(WIDTH)  bit position of sd_digit, MSB first
- neg_en  out  1  enable for the downstream SD2 negation stage

## Operation
- FSM states: IDLE, LOAD, ITER, CORR, DONE.
- IDLE/DONE + start, divisor ≠ 0 → LOAD: latch operands and sgn; clear dz.
- IDLE/DONE + start, divisor = 0 → DONE directly:
  - dz=1, quotient = all ones, remainder = dividend;
  - no digits emitted; neg_en=0.
- DONE without start → IDLE.
- start while busy is ignored.
- LOAD:
  - N = |dividend|, D = |divisor| (magnitudes only when sgn=1; raw values otherwise).
  - qneg = sgn & (dividend[MSB] ^ divisor[MSB]); rneg = sgn & dividend[MSB].
  - R = 0 (signed, WIDTH+2 bits); cnt = WIDTH−1; → ITER.
- ITER step i = cnt:
  - if R ≥ 0: R ← 2R + N[i] − D, digit +1; else R ← 2R + N[i] + D, digit −1.
  - Record digit in P[i] (1 for +1); emit it.
  - cnt = 0 → CORR, else cnt−1.
- CORR:
  - Q = 2P − (2^WIDTH − 1), computed mod 2^WIDTH.
  - If R < 0: R ← R + D and Q ← Q − 1.
  - If qneg, Q ← −Q; if rneg, R ← −R.
  - Register quotient = Q, remainder = R[WIDTH−1:0]; → DONE.
- Signed overflow (−2^(WIDTH−1) / −1) wraps: quotient = −2^(WIDTH−1), remainder = 0, dz=0.
- neg_en = qneg, registered in LOAD, held constant until the next accepted start; forced 0 on divide-by-zero.
- Reset (any state, including mid-operation): abort to IDLE; all outputs 0; P, R, cnt cleared.

## Timing
- Edge E0 samples start; done is high after edge E0+WIDTH+2 for exactly one cycle.
- Divide-by-zero: done high after E0+1.
- busy is high from after E0 through the CORR cycle and low in DONE.
- sd_valid pulses once per ITER edge, registered: W consecutive cycles beginning after E0+2, with sd_idx = WIDTH−1 down to 0.
  - The last digit coincides with the CORR cycle.
- Back-to-back operation: start in the DONE cycle is accepted and yields no idle gap.
- quotient/remainder/dz change only at the DONE-entry edge or on reset.

## Test plan
- Unsigned, WIDTH=8: 200/7 → quotient 28, remainder 4, dz=0, done exactly 10 cycles after start edge, 8 sd_valid pulses.
- Digit stream, WIDTH=3 instance: 7/2 → sd_digit 01, 11, 01 at sd_idx 2, 1, 0; quotient 3, remainder 1, no correction.
- Signed, WIDTH=8:
  - −100/7 → neg_en=1 for the whole run, quotient −14 (0xF2), remainder −2 (0xFE).
  - −128/−1 → quotient 0x80, remainder 0, neg_en=0.
- Divide-by-zero: 55/0 → done 1 cycle after start, dz=1, quotient 0xFF, remainder 55, sd_valid never asserted.
- Handshake/reset:
  - start pulsed while busy → ignored, results unchanged.
  - start in the DONE cycle → new op runs without a gap.
  - rst_n low mid-ITER → all outputs 0 immediately; next start completes normally.
